voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Scheduler between song_reader_new and a bank of NUM_VOICES note_player voices.
//  - Accepts each new_note strobe and assigns it to a free voice.
//  - Counts down each voice's remaining duration on beat, and frees the voice at zero.
//  - Issues a one-hot load pulse to the chosen voice.
//  - Sits inside the note distributor, ahead of the per-voice note_players and the sample mixer.
// PARAMETERS
//  NUM_VOICES  3  number of shared note_player voices (1..8)
//  NOTE_W      6  width of note code; note 0 = rest
//  DUR_W       6  width of duration in beats
// PORTS
//  clk            in   1                      system clock
//  reset          in   1                      synchronous, active-high
//  play           in   1                      high = playing; low = paused
//  beat           in   1                      one-cycle beat tick
//  load_new_note  in   1                      one-cycle strobe, note_in/duration_in valid
//  note_in        in   NOTE_W                 note to schedule
//  duration_in    in   DUR_W                  note length in beats
//  voice_load     out  NUM_VOICES             one-hot, one-cycle load pulse to selected voice
//  voice_note     out  NOTE_W                 note for the voice being loaded
//  voice_duration out  DUR_W                  duration for the voice being loaded
//  voice_busy     out  NUM_VOICES             bit i high while voice i is sounding
//  active_count   out  $clog2(NUM_VOICES+1)   number of busy voices
//  note_dropped   out  1                      one-cycle pulse: note could not be placed
// BEHAVIOUR
//  - Reset: all outputs 0, all remain[i] counters 0, all voices free.
//    Reset wins over every other input in the same cycle.
//  - Per-voice state: remain[i] (DUR_W bits); voice_busy[i] = (remain[i] != 0), registered.
//  - Accept: load_new_note && play && note_in != 0 && duration_in != 0.
//    Otherwise the strobe is ignored: no load, no drop.
//    A rest (note 0) or zero duration never occupies a voice.
//  - Selection: lowest-index voice with remain == 0 at the strobe cycle.
//  - Latency is one cycle. Strobe at cycle t gives, at t+1:
//    - voice_load = one-hot of the selected voice;
//    - voice_note and voice_duration hold the strobe values;
//    - remain[sel] = duration_in.
//    voice_note and voice_duration hold their last value when voice_load = 0.
//  - Beat: if play, every remain[i] != 0 decrements by 1 (no underflow below 0).
//    If play = 0, counters are frozen.
//  - Beat and accept in the same cycle:
//    - All existing counters decrement first.
//    - A voice reaching 0 on that beat is NOT available to this strobe; it is freed at t+1.
//    - The newly loaded voice gets the full duration_in, not decremented this cycle.
//  - All voices busy on accept: see CONFIGURATION.
//  - active_count = popcount(voice_busy), registered alongside voice_busy.
//  - Strobes on consecutive cycles are each handled independently.
//    The busy state updated at t+1 is used for the strobe at t+1.
//  - play falling mid-note: voices stay busy and counters hold.
//    Resumes counting when play returns.
// CONFIGURATION
//  Macro VOICE_STEAL_EN.
//  - Defined: with all voices busy, steal the voice with the smallest remain.
//    Ties go to the lowest index. The steal gives a normal voice_load pulse;
//    note_dropped stays 0.
//  - Undefined: the note is discarded, note_dropped pulses for one cycle at t+1,
//    voice_load stays 0, and no counter changes except from beat.
// TESTING (NUM_VOICES=3)
//  1. Reset, play=1; strobe note 20 dur 4
//     -> next cycle voice_load=001, voice_note=20, voice_busy=001, active_count=1.
//     After 4 beats busy=000.
//  2. Three strobes (dur 5,3,7) on consecutive cycles
//     -> loads 001, 010, 100; busy=111; active_count=3.
//  3. All busy (remain 5,3,7); fourth strobe
//     -> VOICE_STEAL_EN: voice_load=010, remain[1]=new dur.
//     -> Else: note_dropped=1, voice_load=000, counters unchanged.
//  4. Voice0 remain=1; beat and strobe same cycle with voice1 free
//     -> loads voice1 (010); voice0 freed at t+1, not reused.
//  5. Strobe with note_in=0 or duration_in=0, or with play=0
//     -> no voice_load, no note_dropped.
//     play=0 with beats -> counters frozen.
//  6. Reset asserted mid-note with busy=111
//     -> next cycle all outputs 0; a strobe during reset is ignored.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: assigns incoming notes to a bank of shared note_player voices,
// counts each voice's remaining beats and frees it when the count reaches zero.
// Optional feature macro VOICE_STEAL_EN: when every voice is busy, the voice
// with the fewest remaining beats is reused instead of dropping the new note.
module voice_allocator #(
   parameter int NUM_VOICES = 3,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6,
   localparam int CNT_W     = $clog2(NUM_VOICES + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  play,
   input  logic                  beat,
   input  logic                  load_new_note,
   input  logic [NOTE_W-1:0]     note_in,
   input  logic [DUR_W-1:0]      duration_in,
   output logic [NUM_VOICES-1:0] voice_load,
   output logic [NOTE_W-1:0]     voice_note,
   output logic [DUR_W-1:0]      voice_duration,
   output logic [NUM_VOICES-1:0] voice_busy,
   output logic [CNT_W-1:0]      active_count,
   output logic                  note_dropped
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic [DUR_W-1:0]      remain_q [NUM_VOICES];
   logic [DUR_W-1:0]      remain_d [NUM_VOICES];
   logic [DUR_W-1:0]      remain_dec [NUM_VOICES];
   logic [NUM_VOICES-1:0] free_vec;
   logic [NUM_VOICES-1:0] load_d, load_q;
   logic [NUM_VOICES-1:0] busy_d, busy_q;
   logic [CNT_W-1:0]      count_d, count_q;
   logic [NOTE_W-1:0]     note_d, note_q;
   logic [DUR_W-1:0]      dur_d, dur_q;
   logic                  drop_d, drop_q;
   logic                  accept;
   logic                  tick;
   logic                  sel_found;
   logic [IDX_W-1:0]      sel_idx;
   logic [IDX_W-1:0]      tgt_idx;
   logic                  load_en;

   // A strobe is only a real note when playing and neither a rest nor zero length.
   always_comb begin
      accept = load_new_note && play && (note_in != '0) && (duration_in != '0);
      tick   = beat && play;
   end

   // Per-voice free flag (from the pre-beat count) and beat-decremented count.
   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign free_vec[gi]   = (remain_q[gi] == '0);
      assign remain_dec[gi] = (tick && !free_vec[gi]) ? remain_q[gi] - 1'b1 : remain_q[gi];
      assign load_d[gi]     = load_en && (tgt_idx == IDX_W'(gi));
      assign remain_d[gi]   = load_d[gi] ? duration_in : remain_dec[gi];
      assign busy_d[gi]     = (remain_d[gi] != '0);
   end

   // Lowest-index free voice; a voice hitting zero on this beat is not yet free.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end

`ifdef VOICE_STEAL_EN
   logic [IDX_W-1:0] victim_idx;
   logic [DUR_W-1:0] victim_rem;

   // Voice with the smallest remaining count; strict compare keeps ties at the lowest index.
   always_comb begin
      victim_idx = '0;
      victim_rem = remain_q[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (remain_q[i] < victim_rem) begin
            victim_idx = IDX_W'(i);
            victim_rem = remain_q[i];
         end
      end
   end

   // With stealing, every accepted note is loaded somewhere.
   always_comb begin
      load_en = accept;
      tgt_idx = sel_found ? sel_idx : victim_idx;
      drop_d  = 1'b0;
   end
`else
   // Without stealing, a note finding no free voice is discarded and flagged.
   always_comb begin
      load_en = accept && sel_found;
      tgt_idx = sel_idx;
      drop_d  = accept && !sel_found;
   end
`endif

   // Load data holds its last value between loads; busy count follows the new counts.
   always_comb begin
      note_d  = load_en ? note_in : note_q;
      dur_d   = load_en ? duration_in : dur_q;
      count_d = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         count_d = count_d + CNT_W'(busy_d[i]);
      end
   end

   // State and output registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            remain_q[i] <= '0;
         end
         load_q  <= '0;
         busy_q  <= '0;
         count_q <= '0;
         note_q  <= '0;
         dur_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            remain_q[i] <= remain_d[i];
         end
         load_q  <= load_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         note_q  <= note_d;
         dur_q   <= dur_d;
         drop_q  <= drop_d;
      end
   end

   assign voice_load     = load_q;
   assign voice_note     = note_q;
   assign voice_duration = dur_q;
   assign voice_busy     = busy_q;
   assign active_count   = count_q;
   assign note_dropped   = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator with NUM_VOICES=3; expectations hand-computed.
module tb_voice_allocator;

   logic       clk = 1'b0;
   logic       reset;
   logic       play;
   logic       beat;
   logic       load_new_note;
   logic [5:0] note_in;
   logic [5:0] duration_in;
   logic [2:0] voice_load;
   logic [5:0] voice_note;
   logic [5:0] voice_duration;
   logic [2:0] voice_busy;
   logic [1:0] active_count;
   logic       note_dropped;

   int vec_cnt = 0;
   int err_cnt = 0;

   voice_allocator #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
      .clk            (clk),
      .reset          (reset),
      .play           (play),
      .beat           (beat),
      .load_new_note  (load_new_note),
      .note_in        (note_in),
      .duration_in    (duration_in),
      .voice_load     (voice_load),
      .voice_note     (voice_note),
      .voice_duration (voice_duration),
      .voice_busy     (voice_busy),
      .active_count   (active_count),
      .note_dropped   (note_dropped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // One clock with the given strobe/beat; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic ld, input logic [5:0] n, input logic [5:0] d, input logic bt);
      load_new_note = ld;
      note_in       = n;
      duration_in   = d;
      beat          = bt;
      @(posedge clk);
      #1;
      load_new_note = 1'b0;
      beat          = 1'b0;
   endtask

   task automatic chk_st(input string tag, input logic [2:0] ld, input logic [2:0] busy,
                         input logic [1:0] cnt, input logic drop);
      chk({tag, ".load"}, 32'(voice_load), 32'(ld));
      chk({tag, ".busy"}, 32'(voice_busy), 32'(busy));
      chk({tag, ".cnt"},  32'(active_count), 32'(cnt));
      chk({tag, ".drop"}, 32'(note_dropped), 32'(drop));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 6'd0, 6'd0, 1'b0);
      step(1'b0, 6'd0, 6'd0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; play = 1'b1; beat = 1'b0;
      load_new_note = 1'b0; note_in = '0; duration_in = '0;
      do_reset();
      chk_st("rst", 3'b000, 3'b000, 2'd0, 1'b0);
      chk("rst.note", 32'(voice_note), 32'd0);
      chk("rst.dur",  32'(voice_duration), 32'd0);

      // 1: single note, freed after its 4 beats
      step(1'b1, 6'd20, 6'd4, 1'b0);
      chk_st("t1.load", 3'b001, 3'b001, 2'd1, 1'b0);
      chk("t1.note", 32'(voice_note), 32'd20);
      chk("t1.dur",  32'(voice_duration), 32'd4);
      for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t1.b3", 3'b000, 3'b001, 2'd1, 1'b0);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t1.b4", 3'b000, 3'b000, 2'd0, 1'b0);

      // 2: three consecutive strobes fill the bank
      step(1'b1, 6'd10, 6'd5, 1'b0);
      chk_st("t2.a", 3'b001, 3'b001, 2'd1, 1'b0);
      step(1'b1, 6'd11, 6'd3, 1'b0);
      chk_st("t2.b", 3'b010, 3'b011, 2'd2, 1'b0);
      step(1'b1, 6'd12, 6'd7, 1'b0);
      chk_st("t2.c", 3'b100, 3'b111, 2'd3, 1'b0);
      chk("t2.note", 32'(voice_note), 32'd12);

      // 3: fourth strobe with all voices busy (remain 5,3,7)
      step(1'b1, 6'd13, 6'd2, 1'b0);
`ifdef VOICE_STEAL_EN
      chk_st("t3.steal", 3'b010, 3'b111, 2'd3, 1'b0);
      chk("t3.note", 32'(voice_note), 32'd13);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk("t3.drop_off", 32'(note_dropped), 32'd0);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t3.after", 3'b000, 3'b101, 2'd2, 1'b0);  // remain 3,0,5
`else
      chk_st("t3.drop", 3'b000, 3'b111, 2'd3, 1'b1);
      chk("t3.note_hold", 32'(voice_note), 32'd12);
      chk("t3.dur_hold",  32'(voice_duration), 32'd7);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk("t3.drop_off", 32'(note_dropped), 32'd0);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t3.after", 3'b000, 3'b101, 2'd2, 1'b0);  // remain 2,0,4
`endif

      // 4: voice0 at 1; beat and strobe together must pick voice1
      do_reset();
      step(1'b1, 6'd30, 6'd1, 1'b0);
      chk_st("t4.v0", 3'b001, 3'b001, 2'd1, 1'b0);
      step(1'b1, 6'd31, 6'd2, 1'b1);
      chk_st("t4.v1", 3'b010, 3'b010, 2'd1, 1'b0);
      step(1'b1, 6'd32, 6'd3, 1'b0);
      chk_st("t4.reuse", 3'b001, 3'b011, 2'd2, 1'b0);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t4.b1", 3'b000, 3'b011, 2'd2, 1'b0);  // voice1 kept full duration
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t4.b2", 3'b000, 3'b001, 2'd1, 1'b0);

      // 5: ignored strobes and frozen counters
      do_reset();
      step(1'b1, 6'd0, 6'd5, 1'b0);
      chk_st("t5.rest", 3'b000, 3'b000, 2'd0, 1'b0);
      step(1'b1, 6'd5, 6'd0, 1'b0);
      chk_st("t5.zdur", 3'b000, 3'b000, 2'd0, 1'b0);
      play = 1'b0;
      step(1'b1, 6'd5, 6'd5, 1'b0);
      chk_st("t5.pause", 3'b000, 3'b000, 2'd0, 1'b0);
      play = 1'b1;
      step(1'b1, 6'd7, 6'd2, 1'b0);
      chk_st("t5.load", 3'b001, 3'b001, 2'd1, 1'b0);
      play = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t5.frozen", 3'b000, 3'b001, 2'd1, 1'b0);
      play = 1'b1;
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t5.res1", 3'b000, 3'b001, 2'd1, 1'b0);
      step(1'b0, 6'd0, 6'd0, 1'b1);
      chk_st("t5.res2", 3'b000, 3'b000, 2'd0, 1'b0);

      // 6: rest on a full bank is not a drop; reset mid-note clears everything
      step(1'b1, 6'd1, 6'd9, 1'b0);
      step(1'b1, 6'd2, 6'd9, 1'b0);
      step(1'b1, 6'd3, 6'd9, 1'b0);
      chk_st("t6.full", 3'b100, 3'b111, 2'd3, 1'b0);
      step(1'b1, 6'd0, 6'd3, 1'b0);
      chk_st("t6.rest", 3'b000, 3'b111, 2'd3, 1'b0);
      reset = 1'b1;
      step(1'b1, 6'd4, 6'd4, 1'b1);
      chk_st("t6.rst", 3'b000, 3'b000, 2'd0, 1'b0);
      chk("t6.note", 32'(voice_note), 32'd0);
      chk("t6.dur",  32'(voice_duration), 32'd0);
      reset = 1'b0;
      step(1'b0, 6'd0, 6'd0, 1'b0);
      chk_st("t6.post", 3'b000, 3'b000, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
